// File: rtl/vga_pkg.sv
// Shared frame-buffer geometry, pixel and address types for the VGA scan-out path.
// Screen is 640x480. The buffer is 160x120 words and is shown at 4x scale.
package vga_pkg;

  localparam logic [9:0] H_ACTIVE = 10'd640;
  localparam logic [9:0] V_ACTIVE = 10'd480;
  localparam logic [7:0] FB_W     = 8'd160;
  localparam logic [6:0] FB_H     = 7'd120;
  localparam int         SCALE_SH = 2;
  localparam int         ADDR_W   = 15;
  localparam int         RGB_W    = 12;

  typedef logic [RGB_W-1:0]  rgb_t;
  typedef logic [ADDR_W-1:0] fb_addr_t;

  function automatic logic fb_in_range(input logic [7:0] x, input logic [6:0] y);
    return (x < FB_W) && (y < FB_H);
  endfunction

endpackage

// File: rtl/fb_addr_calc.sv
// Maps buffer (x,y) to a linear word address, y*160 + x, using shifts and adds only.
// Purely combinational (zero latency); no flow control.
module fb_addr_calc
  import vga_pkg::*;
(
  input  logic [7:0] x,
  input  logic [6:0] y,
  output fb_addr_t   addr
);

  fb_addr_t y_ext;
  fb_addr_t x_ext;

  assign y_ext = fb_addr_t'(y);
  assign x_ext = fb_addr_t'(x);

  // 160 = 128 + 32
  assign addr = (y_ext << 7) + (y_ext << 5) + x_ext;

endmodule

// File: rtl/vga_fb_scheduler.sv
// Shares the single frame-buffer RAM port between scan-out reads and a pixel writer.
// One pixel of read latency to rgb_out. The writer stalls (wr_ready=0) only in display slots.
module vga_fb_scheduler
  import vga_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       pix_en,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       hsync_in,
  input  logic       vsync_in,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_x,
  input  logic [6:0] wr_y,
  input  rgb_t       wr_rgb,
  output fb_addr_t   mem_addr,
  output logic       mem_we,
  output rgb_t       mem_wdata,
  input  rgb_t       mem_rdata,
  output rgb_t       rgb_out,
  output logic       hsync_out,
  output logic       vsync_out,
  output logic       frame_start,
  output logic       wr_drop
);

  logic     act;
  logic     disp_slot;
  logic     wr_in_range;
  logic     wr_fire;
  logic     act_d;
  fb_addr_t disp_addr;
  fb_addr_t wr_addr;
  fb_addr_t addr_hold;
  fb_addr_t addr_sel;

  fb_addr_calc u_disp_addr (
    .x    (hcount[SCALE_SH+7:SCALE_SH]),
    .y    (vcount[SCALE_SH+6:SCALE_SH]),
    .addr (disp_addr)
  );

  fb_addr_calc u_wr_addr (
    .x    (wr_x),
    .y    (wr_y),
    .addr (wr_addr)
  );

  assign act         = (hcount < H_ACTIVE) && (vcount < V_ACTIVE);
  assign disp_slot   = act && !pix_en;
  assign wr_in_range = fb_in_range(wr_x, wr_y);

  // Grant depends only on the slot, so the writer never sees a combinational loop through wr_valid.
  // Gating with rst makes mem_we fall immediately on reset, not at the next edge.
  assign wr_ready    = rst && !disp_slot;
  assign wr_fire     = wr_valid && wr_ready;
  assign mem_we      = wr_fire && wr_in_range;
  assign mem_wdata   = wr_rgb;
  assign frame_start = rst && pix_en && (hcount == '0) && (vcount == '0);

  always_comb begin
    addr_sel = addr_hold;
    if (disp_slot) begin
      addr_sel = disp_addr;
    end else if (mem_we) begin
      addr_sel = wr_addr;
    end
  end

  assign mem_addr = rst ? addr_sel : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_hold <= '0;
      wr_drop   <= 1'b0;
      act_d     <= 1'b0;
      rgb_out   <= '0;
      hsync_out <= 1'b1;
      vsync_out <= 1'b1;
    end else begin
      addr_hold <= addr_sel;
      if (wr_fire && !wr_in_range) begin
        wr_drop <= 1'b1;
      end
      // Read issued on the pix_en=0 edge; its data is taken on the following pix_en=1 edge.
      if (!pix_en) begin
        act_d <= act;
      end else begin
        rgb_out   <= act_d ? mem_rdata : '0;
        hsync_out <= hsync_in;
        vsync_out <= vsync_in;
      end
    end
  end

endmodule

// File: tb/tb_vga_fb_scheduler.sv
// Self-checking bench for vga_fb_scheduler: directed scenarios plus a randomized run
// against an image-level model of the frame buffer.
module tb_vga_fb_scheduler;

  logic        clk;
  logic        rst;
  logic        pix_en;
  logic [9:0]  hcount;
  logic [9:0]  vcount;
  logic        hsync_in;
  logic        vsync_in;
  logic        wr_valid;
  logic        wr_ready;
  logic [7:0]  wr_x;
  logic [6:0]  wr_y;
  logic [11:0] wr_rgb;
  logic [14:0] mem_addr;
  logic        mem_we;
  logic [11:0] mem_wdata;
  logic [11:0] mem_rdata;
  logic [11:0] rgb_out;
  logic        hsync_out;
  logic        vsync_out;
  logic        frame_start;
  logic        wr_drop;

  int n_cmp = 0;
  int n_bad = 0;

  vga_fb_scheduler dut (
    .clk(clk), .rst(rst), .pix_en(pix_en), .hcount(hcount), .vcount(vcount),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .rgb_out(rgb_out), .hsync_out(hsync_out),
    .vsync_out(vsync_out), .frame_start(frame_start), .wr_drop(wr_drop)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single-port RAM with one clock of read latency.
  logic [11:0] ram [0:32767];
  logic        ram_clr;
  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 32768; i++) ram[i] <= '0;
      mem_rdata <= '0;
    end else begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      mem_rdata <= ram[mem_addr];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; ram_clr = 1'b1; pix_en = 1'b0; hcount = 10'd100; vcount = 10'd50;
    hsync_in = 1'b1; vsync_in = 1'b1; wr_valid = 1'b0; wr_x = '0; wr_y = '0; wr_rgb = '0;
    tick(); tick(); tick();
    ram_clr = 1'b0;
    // blank-line write of 0x5A5 to (3,3), syncs driven low
    rst = 1'b1; hcount = 10'd100; vcount = 10'd490; pix_en = 1'b1;
    wr_valid = 1'b1; wr_x = 8'd3; wr_y = 7'd3; wr_rgb = 12'h5A5; hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    wr_valid = 1'b0; hcount = 10'd12; vcount = 10'd12; pix_en = 1'b0;
    tick();
    pix_en = 1'b1; wr_valid = 1'b1; wr_x = 8'd200; wr_y = 7'd0;
    tick();
    n_cmp++; if (rgb_out !== 12'h5A5) begin n_bad++; $display("FAIL pre_rgb: got %h want 5a5", rgb_out); end
    n_cmp++; if (wr_drop !== 1'b1) begin n_bad++; $display("FAIL pre_drop: got %b want 1", wr_drop); end
    // mid-transfer at (0,0): write in flight, frame_start would pulse
    hcount = 10'd0; vcount = 10'd0; pix_en = 1'b1; wr_valid = 1'b1; wr_x = 8'd4; wr_y = 7'd4;
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL pre_we: got %b want 1", mem_we); end
    n_cmp++; if (frame_start !== 1'b1) begin n_bad++; $display("FAIL pre_fs: got %b want 1", frame_start); end
    rst = 1'b0;
    #1;
    n_cmp++; if (rgb_out !== 12'h000) begin n_bad++; $display("FAIL rst_rgb: got %h want 000", rgb_out); end
    n_cmp++; if (hsync_out !== 1'b1) begin n_bad++; $display("FAIL rst_hsync: got %b want 1", hsync_out); end
    n_cmp++; if (vsync_out !== 1'b1) begin n_bad++; $display("FAIL rst_vsync: got %b want 1", vsync_out); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rst_we: got %b want 0", mem_we); end
    n_cmp++; if (mem_addr !== 15'd0) begin n_bad++; $display("FAIL rst_addr: got %0d want 0", mem_addr); end
    n_cmp++; if (frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_fs: got %b want 0", frame_start); end
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL rst_drop: got %b want 0", wr_drop); end
    tick();
    // release into a display slot: the re-presented write must wait
    rst = 1'b1; pix_en = 1'b0;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL rel_we: got %b want 0", mem_we); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rel_rdy: got %b want 0", wr_ready); end
    n_cmp++; if (mem_addr !== 15'd0) begin n_bad++; $display("FAIL rel_addr: got %0d want 0", mem_addr); end
    tick();
    pix_en = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL rel_we2: got %b want 1", mem_we); end
    n_cmp++; if (mem_addr !== 15'd644) begin n_bad++; $display("FAIL rel_addr2: got %0d want 644", mem_addr); end
    tick();
    wr_valid = 1'b0;
  endtask

  task automatic test_display_read();
    hcount = 10'd100; vcount = 10'd500; pix_en = 1'b1;
    wr_valid = 1'b1; wr_x = 8'd2; wr_y = 7'd1; wr_rgb = 12'hF00;
    tick();
    wr_valid = 1'b0; hcount = 10'd8; vcount = 10'd4; pix_en = 1'b0;
    #1;
    n_cmp++; if (mem_addr !== 15'd162) begin n_bad++; $display("FAIL rd_addr: got %0d want 162", mem_addr); end
    n_cmp++; if (wr_ready !== 1'b0) begin n_bad++; $display("FAIL rd_rdy: got %b want 0", wr_ready); end
    tick();
    pix_en = 1'b1;
    tick();
    n_cmp++; if (rgb_out !== 12'hF00) begin n_bad++; $display("FAIL rd_rgb: got %h want f00", rgb_out); end
  endtask

  task automatic test_active_write();
    int          xfers;
    logic        pend;
    logic        e_we;
    logic [14:0] e_addr;
    xfers = 0; pend = 1'b1;
    hcount = 10'd40; vcount = 10'd40; wr_x = 8'd159; wr_y = 7'd119; wr_rgb = 12'hABC;
    for (int c = 0; c < 4; c++) begin
      pix_en = c[0]; wr_valid = pend;
      #1;
      e_we   = pend && c[0];
      e_addr = e_we ? 15'd19199 : 15'd1610;
      n_cmp++; if (wr_ready !== c[0]) begin n_bad++; $display("FAIL aw_rdy[%0d]: got %b want %b", c, wr_ready, c[0]); end
      n_cmp++; if (mem_we !== e_we) begin n_bad++; $display("FAIL aw_we[%0d]: got %b want %b", c, mem_we, e_we); end
      n_cmp++; if (mem_addr !== e_addr) begin n_bad++; $display("FAIL aw_addr[%0d]: got %0d want %0d", c, mem_addr, e_addr); end
      if (wr_valid && wr_ready) begin xfers++; pend = 1'b0; end
      tick();
    end
    wr_valid = 1'b0;
    n_cmp++; if (xfers != 1) begin n_bad++; $display("FAIL aw_xfers: got %0d want 1", xfers); end
    hcount = 10'd636; vcount = 10'd476; pix_en = 1'b0;
    tick();
    pix_en = 1'b1;
    tick();
    n_cmp++; if (rgb_out !== 12'hABC) begin n_bad++; $display("FAIL aw_readback: got %h want abc", rgb_out); end
  endtask

  task automatic test_vblank_burst();
    int          xfers;
    logic [14:0] e_addr;
    xfers = 0; hcount = 10'd200; vcount = 10'd490;
    for (int i = 0; i < 8; i++) begin
      pix_en = i[0]; wr_valid = 1'b1; wr_x = 8'(i * 3); wr_y = 7'(100 + i); wr_rgb = 12'($urandom);
      #1;
      e_addr = 15'((100 + i) * 160 + i * 3);
      n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL vb_rdy[%0d]: got %b want 1", i, wr_ready); end
      n_cmp++; if (mem_we !== 1'b1) begin n_bad++; $display("FAIL vb_we[%0d]: got %b want 1", i, mem_we); end
      n_cmp++; if (mem_addr !== e_addr) begin n_bad++; $display("FAIL vb_addr[%0d]: got %0d want %0d", i, mem_addr, e_addr); end
      if (wr_valid && wr_ready) xfers++;
      tick();
    end
    wr_valid = 1'b0;
    n_cmp++; if (xfers != 8) begin n_bad++; $display("FAIL vb_xfers: got %0d want 8", xfers); end
  endtask

  task automatic test_drop();
    hcount = 10'd300; vcount = 10'd500; pix_en = 1'b0;
    wr_valid = 1'b1; wr_x = 8'd160; wr_y = 7'd5; wr_rgb = 12'h777;
    #1;
    n_cmp++; if (wr_ready !== 1'b1) begin n_bad++; $display("FAIL dr_rdy: got %b want 1", wr_ready); end
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL dr_we: got %b want 0", mem_we); end
    tick();
    n_cmp++; if (wr_drop !== 1'b1) begin n_bad++; $display("FAIL dr_set: got %b want 1", wr_drop); end
    for (int i = 0; i < 6; i++) begin
      pix_en = i[0]; wr_x = 8'($urandom_range(0, 159)); wr_y = 7'($urandom_range(0, 119));
      tick();
    end
    wr_valid = 1'b0;
    n_cmp++; if (wr_drop !== 1'b1) begin n_bad++; $display("FAIL dr_sticky: got %b want 1", wr_drop); end
    rst = 1'b0;
    #1;
    n_cmp++; if (wr_drop !== 1'b0) begin n_bad++; $display("FAIL dr_clr: got %b want 0", wr_drop); end
    tick();
    rst = 1'b1;
    // y just past the last row
    wr_valid = 1'b1; wr_x = 8'd0; wr_y = 7'd120; pix_en = 1'b1;
    #1;
    n_cmp++; if (mem_we !== 1'b0) begin n_bad++; $display("FAIL dr_y_we: got %b want 0", mem_we); end
    tick();
    wr_valid = 1'b0;
    n_cmp++; if (wr_drop !== 1'b1) begin n_bad++; $display("FAIL dr_y_set: got %b want 1", wr_drop); end
  endtask

  task automatic test_blank_sync();
    int fs_cnt;
    hcount = 10'd300; vcount = 10'd500; pix_en = 1'b1;
    wr_valid = 1'b1; wr_x = 8'd5; wr_y = 7'd5; wr_rgb = 12'hFFF; hsync_in = 1'b1; vsync_in = 1'b1;
    tick();
    wr_valid = 1'b0; hcount = 10'd700; vcount = 10'd100; pix_en = 1'b0;
    #1;
    n_cmp++; if (mem_addr !== 15'd805) begin n_bad++; $display("FAIL bl_hold: got %0d want 805", mem_addr); end
    tick();
    pix_en = 1'b1;
    tick();
    n_cmp++; if (rgb_out !== 12'h000) begin n_bad++; $display("FAIL bl_rgb: got %h want 000", rgb_out); end
    n_cmp++; if (hsync_out !== 1'b1) begin n_bad++; $display("FAIL bl_hs1: got %b want 1", hsync_out); end
    pix_en = 1'b0; hsync_in = 1'b0; vsync_in = 1'b0;
    tick();
    n_cmp++; if (hsync_out !== 1'b1) begin n_bad++; $display("FAIL bl_hs_lag: got %b want 1", hsync_out); end
    pix_en = 1'b1;
    tick();
    n_cmp++; if (hsync_out !== 1'b0) begin n_bad++; $display("FAIL bl_hs0: got %b want 0", hsync_out); end
    n_cmp++; if (vsync_out !== 1'b0) begin n_bad++; $display("FAIL bl_vs0: got %b want 0", vsync_out); end
    for (int f = 0; f < 3; f++) begin
      fs_cnt = 0;
      for (int p = 0; p < 4; p++) begin
        hcount = (p == 0) ? 10'd0 : (p == 1) ? 10'd1 : (p == 2) ? 10'd639 : 10'd799;
        vcount = (p == 0) ? 10'd0 : (p == 1) ? 10'd0 : (p == 2) ? 10'd479 : 10'd524;
        for (int ph = 0; ph < 2; ph++) begin
          pix_en = ph[0];
          #1;
          if (frame_start === 1'b1) fs_cnt++;
          tick();
        end
      end
      n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL fs_count[%0d]: got %0d want 1", f, fs_cnt); end
    end
  endtask

  task automatic test_random();
    logic [11:0] img [0:19199];
    logic [14:0] m_last;
    logic [11:0] m_pix;
    logic [11:0] e_rgb;
    logic        e_hs, e_vs, m_drop;
    logic        act, disp, in_rng, e_we, e_fs, done;
    logic [14:0] e_addr;
    int          h, v;
    for (int i = 0; i < 19200; i++) img[i] = '0;
    rst = 1'b0; ram_clr = 1'b1; wr_valid = 1'b0;
    tick(); tick();
    ram_clr = 1'b0; rst = 1'b1;
    m_last = '0; m_pix = '0; e_rgb = '0; e_hs = 1'b1; e_vs = 1'b1; m_drop = 1'b0;
    for (int p = 0; p < 500; p++) begin
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(640, 799)) : int'($urandom_range(0, 639));
      v = ($urandom_range(0, 7) == 0) ? int'($urandom_range(480, 524)) : int'($urandom_range(0, 479));
      if ($urandom_range(0, 15) == 0) begin h = 0; v = 0; end
      for (int ph = 0; ph < 2; ph++) begin
        pix_en = ph[0]; hcount = 10'(h); vcount = 10'(v);
        hsync_in = 1'($urandom_range(0, 1)); vsync_in = 1'($urandom_range(0, 1));
        if (!wr_valid && $urandom_range(0, 1) == 1) begin
          wr_valid = 1'b1; wr_x = 8'($urandom_range(0, 167)); wr_y = 7'($urandom_range(0, 125));
          wr_rgb = 12'($urandom);
        end
        #1;
        act    = (h < 640) && (v < 480);
        disp   = act && (ph == 0);
        in_rng = (wr_x < 160) && (wr_y < 120);
        e_we   = wr_valid && !disp && in_rng;
        e_fs   = (ph == 1) && (h == 0) && (v == 0);
        if (disp) e_addr = 15'((v / 4) * 160 + h / 4);
        else if (e_we) e_addr = 15'(int'(wr_y) * 160 + int'(wr_x));
        else e_addr = m_last;
        n_cmp++; if (wr_ready !== !disp) begin n_bad++; $display("FAIL rn_rdy[%0d.%0d]: got %b want %b", p, ph, wr_ready, !disp); end
        n_cmp++; if (mem_we !== e_we) begin n_bad++; $display("FAIL rn_we[%0d.%0d]: got %b want %b", p, ph, mem_we, e_we); end
        n_cmp++; if (mem_addr !== e_addr) begin n_bad++; $display("FAIL rn_addr[%0d.%0d]: got %0d want %0d", p, ph, mem_addr, e_addr); end
        n_cmp++; if (frame_start !== e_fs) begin n_bad++; $display("FAIL rn_fs[%0d.%0d]: got %b want %b", p, ph, frame_start, e_fs); end
        if (e_we) begin
          n_cmp++; if (mem_wdata !== wr_rgb) begin n_bad++; $display("FAIL rn_wdata[%0d.%0d]: got %h want %h", p, ph, mem_wdata, wr_rgb); end
        end
        m_last = e_addr;
        if (ph == 0) m_pix = act ? img[int'(e_addr)] : 12'h000;
        if (e_we) img[int'(e_addr)] = wr_rgb;
        if (wr_valid && !disp && !in_rng) m_drop = 1'b1;
        done = wr_valid && !disp;
        if (ph == 1) begin e_rgb = m_pix; e_hs = hsync_in; e_vs = vsync_in; end
        tick();
        if (done) wr_valid = 1'b0;
        n_cmp++; if (rgb_out !== e_rgb) begin n_bad++; $display("FAIL rn_rgb[%0d.%0d]: got %h want %h", p, ph, rgb_out, e_rgb); end
        n_cmp++; if (hsync_out !== e_hs) begin n_bad++; $display("FAIL rn_hs[%0d.%0d]: got %b want %b", p, ph, hsync_out, e_hs); end
        n_cmp++; if (vsync_out !== e_vs) begin n_bad++; $display("FAIL rn_vs[%0d.%0d]: got %b want %b", p, ph, vsync_out, e_vs); end
        n_cmp++; if (wr_drop !== m_drop) begin n_bad++; $display("FAIL rn_drop[%0d.%0d]: got %b want %b", p, ph, wr_drop, m_drop); end
      end
    end
    wr_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_display_read();
    test_active_write();
    test_vblank_burst();
    test_drop();
    test_blank_sync();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
